tmr_fault_injector: RTL and testbench
=====================================

# tmr_fault_injector

Campaign controller that drives single-net bit-flips into a TMR-hardened design and observes that design's error-sink output. It is the stimulus-side counterpart of the error sink: the sink reports faults, this block creates them and measures whether and when the sink reports them. It sits in the test harness between a host/sequencer and the DUT. `flip_o` is XORed onto the DUT's selected internal nets, and the DUT's error-sink output returns on `err_i`.

## Interface
- `N_TARGETS`, default 8: number of injectable nets (width of `flip_o`), ≥ 2.
- `TGT_W`, default `$clog2(N_TARGETS)`: width of the target index.
- `CNT_W`, default 16: width of the delay, duration, timeout and latency fields.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `start_i` in 1: start request, sampled only in IDLE.
- `target_i` in TGT_W: net index to flip.
- `delay_i` in CNT_W: cycles from accept to first inject cycle, minus one.
- `duration_i` in CNT_W: number of inject cycles; 0 is treated as 1.
- `timeout_i` in CNT_W: maximum latency (in cycles) waited for `err_i`.
- `err_i` in 1: DUT error-sink output, synchronous to `clk_i`.
- `flip_o` out N_TARGETS: one-hot XOR mask, registered.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle pulse at campaign end.
- `detected_o` out 1: `err_i` was seen from the first inject cycle onward.
- `timeout_o` out 1: the timeout expired without `err_i`.
- `spurious_o` out 1: sticky; `err_i` was seen during DELAY.
- `latency_o` out CNT_W: cycles from the first inject cycle to the first `err_i`.

## Operation
- FSM states: IDLE, DELAY, INJECT, WAIT_ERR, DONE.
- **IDLE**
  - When `start_i` is high, latch `target_i`, `delay_i`, `duration_i` (0→1) and `timeout_i`.
  - Clear `detected_o`, `timeout_o`, `spurious_o` and `latency_o`, then go to DELAY.
- **DELAY**
  - A down-counter is loaded with `delay`; go to INJECT in the cycle where the counter equals 0.
  - `err_i` high in this state sets `spurious_o`. The campaign continues.
- **INJECT**
  - `flip_o` = one-hot(target) for exactly `duration` cycles.
  - If target ≥ `N_TARGETS`, `flip_o` stays all-zero and the campaign still runs.
- **Latency counter**
  - Starts at 0 in the first INJECT cycle and increments every cycle, saturating at all-ones.
  - The first `err_i` high in INJECT or WAIT_ERR freezes `latency_o` at the counter value and sets `detected_o`.
  - Later `err_i` pulses are ignored.
- **After INJECT**
  - If detected, go to DONE; otherwise go to WAIT_ERR.
  - Injection always runs its full duration, even when `err_i` arrives early.
- **WAIT_ERR**
  - `flip_o` = 0.
  - `err_i` high: record detection as above and go to DONE.
  - Else, if counter ≥ `timeout_i`: set `timeout_o`, set `latency_o` = counter, go to DONE.
  - If `err_i` and the timeout condition occur in the same cycle, detection wins.
- **DONE**: `done_o` = 1 for one cycle, then go to IDLE.
- **Result hold**: result outputs hold until the next accepted start. `start_i` while busy is ignored, with no queueing.

## Timing
- **Reset values**: all outputs are 0 and the state is IDLE. Reset mid-campaign clears `flip_o` asynchronously, with no completion pulse.
- **Start accept and first inject**: `start_i` is accepted at clock edge k. `busy_o` is high from k+1. `flip_o` is high from edge k+1+delay through k+delay+duration inclusive.
- **`err_i` sampling**: `err_i` is sampled on the same edge at which `flip_o` is updated. If `err_i` is high in the first inject cycle, latency is 0.
- **`done_o`**: asserted the cycle after detection or timeout, or the cycle after the last inject cycle if detection happened during INJECT. Results are valid in the same cycle as `done_o`.
- **Back-to-back campaigns**: the earliest re-start is accepted in the cycle after DONE, so there is one IDLE cycle between campaigns.

## Test plan
- **Delayed detection**: target=3, delay=2, duration=1, timeout=10, `err_i` pulsed 2 cycles after the flip → `flip_o`=8'h08 for 1 cycle; `detected_o`=1, `latency_o`=2, `timeout_o`=0, one `done_o` pulse.
- **No detection**: target=0, delay=0, duration=3, timeout=5, `err_i`=0 → `flip_o`=8'h01 starting the cycle after accept, for 3 cycles; `timeout_o`=1, `latency_o`=5, `detected_o`=0.
- **Early error during inject**: duration=4, `err_i` high in the first inject cycle → `latency_o`=0 and `flip_o` held for all 4 cycles. A second `err_i` pulse in WAIT has no effect.
- **Spurious error and duration 0**: `err_i` high during DELAY → `spurious_o`=1 while the campaign still completes. duration=0 → exactly 1 inject cycle.
- **Out-of-range target and ignored start**: target=9 with `N_TARGETS`=8 → `flip_o` stays 0 and timeout is reported. `start_i` held high while busy does not re-trigger.
- **Reset mid-inject**: `rst_ni` dropped mid-INJECT → `flip_o`=0 immediately, no `done_o`. A new campaign after reset completes normally.

Source files
------------

// File: rtl/tmr_fault_injector.sv
// Fault-injection campaign controller: flips one DUT net for a programmed window
// and measures whether and when the DUT's error sink reports it.
module tmr_fault_injector #(
  parameter int N_TARGETS = 8,
  parameter int TGT_W     = $clog2(N_TARGETS),
  parameter int CNT_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [TGT_W-1:0]     target_i,
  input  logic [CNT_W-1:0]     delay_i,
  input  logic [CNT_W-1:0]     duration_i,
  input  logic [CNT_W-1:0]     timeout_i,
  input  logic                 err_i,
  output logic [N_TARGETS-1:0] flip_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 detected_o,
  output logic                 timeout_o,
  output logic                 spurious_o,
  output logic [CNT_W-1:0]     latency_o
);

  typedef enum logic [2:0] {IDLE, DELAY, INJECT, WAIT_ERR, DONE} state_e;

  state_e               state_q, state_d;
  logic [TGT_W-1:0]     tgt_q, tgt_d;
  logic [CNT_W-1:0]     dur_q, dur_d;
  logic [CNT_W-1:0]     tmo_q, tmo_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     lat_q, lat_d;
  logic [CNT_W-1:0]     latency_q, latency_d;
  logic                 detected_q, detected_d;
  logic                 timeout_q, timeout_d;
  logic                 spurious_q, spurious_d;
  logic [N_TARGETS-1:0] flip_q, flip_d;
  logic [N_TARGETS-1:0] onehot;
  logic                 cnt_zero, err_hit;

  assign cnt_zero = (cnt_q == '0);
  // Only the first error after injection starts counts as a detection.
  assign err_hit  = err_i && !detected_q &&
                    (state_q == INJECT || state_q == WAIT_ERR);

  // Out-of-range targets match no bit, so the mask stays zero.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < N_TARGETS; i++)
      if (tgt_q == TGT_W'(i)) onehot[i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start_i) state_d = DELAY;
      DELAY:    if (cnt_zero) state_d = INJECT;
      INJECT:   if (cnt_zero) state_d = (detected_q || err_i) ? DONE : WAIT_ERR;
      WAIT_ERR: if (err_i || lat_q >= tmo_q) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    tgt_d      = tgt_q;
    dur_d      = dur_q;
    tmo_d      = tmo_q;
    cnt_d      = cnt_q;
    lat_d      = lat_q;
    latency_d  = latency_q;
    detected_d = detected_q;
    timeout_d  = timeout_q;
    spurious_d = spurious_q;
    flip_d     = (state_d == INJECT) ? onehot : '0;

    unique case (state_q)
      IDLE: if (start_i) begin
        tgt_d      = target_i;
        dur_d      = (duration_i == '0) ? CNT_W'(1) : duration_i;
        tmo_d      = timeout_i;
        cnt_d      = delay_i;
        latency_d  = '0;
        detected_d = 1'b0;
        timeout_d  = 1'b0;
        spurious_d = 1'b0;
      end
      DELAY: begin
        if (err_i) spurious_d = 1'b1;
        lat_d = '0;
        cnt_d = cnt_zero ? dur_q - CNT_W'(1) : cnt_q - CNT_W'(1);
      end
      INJECT: if (!cnt_zero) cnt_d = cnt_q - CNT_W'(1);
      WAIT_ERR: if (!err_i && lat_q >= tmo_q) begin
        timeout_d = 1'b1;
        latency_d = lat_q;
      end
      default: ;
    endcase

    if ((state_q == INJECT || state_q == WAIT_ERR) && lat_q != '1)
      lat_d = lat_q + CNT_W'(1);
    if (err_hit) begin
      detected_d = 1'b1;
      latency_d  = lat_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tgt_q      <= '0;
      dur_q      <= '0;
      tmo_q      <= '0;
      cnt_q      <= '0;
      lat_q      <= '0;
      latency_q  <= '0;
      detected_q <= 1'b0;
      timeout_q  <= 1'b0;
      spurious_q <= 1'b0;
      flip_q     <= '0;
    end else begin
      tgt_q      <= tgt_d;
      dur_q      <= dur_d;
      tmo_q      <= tmo_d;
      cnt_q      <= cnt_d;
      lat_q      <= lat_d;
      latency_q  <= latency_d;
      detected_q <= detected_d;
      timeout_q  <= timeout_d;
      spurious_q <= spurious_d;
      flip_q     <= flip_d;
    end
  end

  always_comb begin
    busy_o     = (state_q != IDLE);
    done_o     = (state_q == DONE);
    flip_o     = flip_q;
    detected_o = detected_q;
    timeout_o  = timeout_q;
    spurious_o = spurious_q;
    latency_o  = latency_q;
  end

endmodule

// File: tb/tb_tmr_fault_injector.sv
// Directed bench for tmr_fault_injector: each campaign is run cycle by cycle and
// its flip window, completion timing and result fields compared to hand values.
module tb_tmr_fault_injector;
  localparam int N = 8, TW = 4, CW = 16;

  logic          clk_i = 1'b0, rst_ni = 1'b0;
  logic          start_i = 1'b0, err_i = 1'b0;
  logic [TW-1:0] target_i = '0;
  logic [CW-1:0] delay_i = '0, duration_i = '0, timeout_i = '0;
  logic [N-1:0]  flip_o;
  logic          busy_o, done_o, detected_o, timeout_o, spurious_o;
  logic [CW-1:0] latency_o;

  tmr_fault_injector #(.N_TARGETS(N), .TGT_W(TW), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .target_i(target_i),
    .delay_i(delay_i), .duration_i(duration_i), .timeout_i(timeout_i),
    .err_i(err_i), .flip_o(flip_o), .busy_o(busy_o), .done_o(done_o),
    .detected_o(detected_o), .timeout_o(timeout_o), .spurious_o(spurious_o),
    .latency_o(latency_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Campaign observations; m counts edges after the accepting edge.
  int         first_m, flip_cnt, done_cnt, done_m;
  logic [N-1:0] flip_or;
  logic       r_det, r_tmo, r_spur, busy1, busy2;
  logic [CW-1:0] r_lat;

  task automatic campaign(input logic [TW-1:0] tgt, input int dly, input int dur,
                          input int tmo, input int e1, input int e2, input bit hold);
    first_m = -1; flip_cnt = 0; done_cnt = 0; done_m = -1; flip_or = '0;
    r_det = 0; r_tmo = 0; r_spur = 0; r_lat = '0; busy1 = 1'bx; busy2 = 1'bx;
    start_i = 1; target_i = tgt;
    delay_i = CW'(dly); duration_i = CW'(dur); timeout_i = CW'(tmo);
    @(posedge clk_i); #1;
    if (!hold) start_i = 0;
    for (int m = 0; m < 200; m++) begin
      if (flip_o != '0) begin
        if (first_m < 0) first_m = m;
        flip_cnt++;
        flip_or |= flip_o;
      end
      if (done_o) begin
        done_cnt++;
        if (done_m < 0) begin
          done_m = m; r_det = detected_o; r_tmo = timeout_o;
          r_spur = spurious_o; r_lat = latency_o;
        end
      end
      if (done_m >= 0 && m == done_m + 1) busy1 = busy_o;
      if (done_m >= 0 && m == done_m + 2) begin busy2 = busy_o; break; end
      err_i = (m == e1 || m == e2);
      @(posedge clk_i); #1;
    end
    err_i = 0; start_i = 0;
  endtask

  task automatic expect_res(input string t, input int ff, input int fc, input logic [N-1:0] fo,
                            input int dm, input logic det, input logic tmo, input logic sp,
                            input int lat, input logic b2);
    check({t, ".first_flip"}, first_m, ff);
    check({t, ".flip_cycles"}, flip_cnt, fc);
    check({t, ".flip_mask"}, flip_or, fo);
    check({t, ".done_cycle"}, done_m, dm);
    check({t, ".done_pulses"}, done_cnt, 1);
    check({t, ".detected"}, r_det, det);
    check({t, ".timeout"}, r_tmo, tmo);
    check({t, ".spurious"}, r_spur, sp);
    check({t, ".latency"}, r_lat, lat);
    check({t, ".idle_gap"}, busy1, 0);
    check({t, ".busy_after"}, busy2, b2);
  endtask

  initial begin
    int dones;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst.flip", flip_o, 0);
    check("rst.busy", busy_o, 0);
    check("rst.done", done_o, 0);
    check("rst.flags", {detected_o, timeout_o, spurious_o}, 0);
    check("rst.latency", latency_o, 0);
    rst_ni = 1;
    @(posedge clk_i); #1;

    campaign(3, 2, 1, 10, 5, -1, 0);
    expect_res("delayed", 3, 1, 8'h08, 6, 1, 0, 0, 2, 0);
    campaign(0, 0, 3, 5, -1, -1, 0);
    expect_res("nodet", 1, 3, 8'h01, 7, 0, 1, 0, 5, 0);
    campaign(5, 1, 4, 20, 2, 4, 0);
    expect_res("early", 2, 4, 8'h20, 6, 1, 0, 0, 0, 0);
    campaign(7, 3, 0, 4, 1, -1, 0);
    expect_res("spur", 4, 1, 8'h80, 9, 0, 1, 1, 4, 0);
    campaign(9, 1, 2, 3, -1, -1, 1);
    expect_res("oor", -1, 0, 8'h00, 6, 0, 1, 0, 3, 1);

    // start was held through the last campaign, so a re-run is in flight
    for (int i = 0; i < 50 && busy_o; i++) begin @(posedge clk_i); #1; end
    check("oor.rerun_ends", busy_o, 0);

    start_i = 1; target_i = 2; delay_i = 0; duration_i = 6; timeout_i = 10;
    @(posedge clk_i); #1;
    start_i = 0;
    @(posedge clk_i); #1;
    check("rstmid.flip_pre", flip_o, 8'h04);
    #2 rst_ni = 0;
    #1;
    check("rstmid.flip", flip_o, 0);
    check("rstmid.busy", busy_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1;
    dones = 0;
    repeat (4) begin
      dones += int'(done_o);
      @(posedge clk_i); #1;
    end
    check("rstmid.no_done", dones, 0);

    campaign(1, 1, 1, 2, -1, -1, 0);
    expect_res("after_rst", 2, 1, 8'h02, 5, 0, 1, 0, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
